start_initiator: RTL and testbench

START_INITIATOR -- requirements
Module: start_initiator

---
 rtl/start_initiator.sv | 103 ++++++++++
 tb/tb_start_initiator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/start_initiator.sv
// Start/done handshake initiator: holds start for a programmable number of cycles,
// then waits a bounded time for the responder's done pulse.
module start_initiator #(
  parameter int N   = 3,
  parameter int TMO = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [N-1:0] hold_len,
  input  logic         done,
  output logic         start,
  output logic         busy,
  output logic         ack,
  output logic         early,
  output logic         timeout,
  output logic [N:0]   cycles
);

  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  hold_val;
  logic [N:0]    hold_cnt;
  logic [WW-1:0] wait_cnt;
  logic          early_q;
  logic          timeout_q;
  logic          hold_last;
  logic          wait_last;

  // hold_cnt counts start-high cycles including the current one
  assign hold_last = (hold_cnt == {1'b0, hold_val});
  assign wait_last = (wait_cnt == WW'(TMO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (go) state_d = ASSERT;
      ASSERT: begin
        if (done)           state_d = FINISH;
        else if (hold_last) state_d = WAIT;
      end
      WAIT: begin
        if (done)           state_d = FINISH;
        else if (wait_last) state_d = IDLE;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_val  <= '0;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      cycles    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            hold_val <= (hold_len == '0) ? N'(1) : hold_len;
            hold_cnt <= (N+1)'(1);
            early_q  <= 1'b0;
          end
        end
        ASSERT: begin
          if (state_d == ASSERT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            cycles   <= hold_cnt;
            wait_cnt <= '0;
          end
          if (done) early_q <= 1'b1;
        end
        WAIT: begin
          if (!done) begin
            if (wait_last) timeout_q <= 1'b1;
            else           wait_cnt  <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start   = (state_q == ASSERT);
  assign busy    = (state_q != IDLE);
  assign ack     = (state_q == FINISH);
  assign early   = (state_q == FINISH) && early_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_start_initiator.sv
// Directed bench for start_initiator: transaction table plus back-to-back and reset sequences.
module tb_start_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [2:0] hold_len;
  logic       done;
  logic       start, busy, ack, early, timeout;
  logic [3:0] cycles;

  int tests = 0;
  int fails = 0;

  start_initiator #(.N(3), .TMO(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .hold_len (hold_len),
    .done     (done),
    .start    (start),
    .busy     (busy),
    .ack      (ack),
    .early    (early),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // done_at: index of the start-relative cycle in which done is high; -1 = never
  typedef struct {
    logic [2:0] hl;
    int done_at;
    int e_start;
    int e_cycles;
    int e_ack;
    int e_early;
    int e_to;
    int e_wait;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ns, nw, na, ne, nt, nboth, cyc;
    bit finished;
    logic [2:0] seq_exp[8];

    vecs[0] = '{3'd3,  4, 3, 3, 1, 0, 0, 2};
    vecs[1] = '{3'd0,  2, 1, 1, 1, 0, 0, 2};
    vecs[2] = '{3'd7,  3, 4, 4, 1, 1, 0, 0};
    vecs[3] = '{3'd2, -1, 2, 2, 0, 0, 1, 4};
    vecs[4] = '{3'd3,  2, 3, 3, 1, 1, 0, 0};
    vecs[5] = '{3'd1,  0, 1, 1, 1, 1, 0, 0};
    vecs[6] = '{3'd5,  8, 5, 5, 1, 0, 0, 4};

    reset = 1'b1; go = 1'b0; done = 1'b0; hold_len = '0;
    #3 reset = 1'b0;
    #1;
    check("rst_async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("rst_outputs", int'({start, busy, ack, early, timeout, cycles}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // done while idle must not start anything
    done = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_done_ignored", int'({start, busy, ack, timeout}), 0);
    done = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      go = 1'b1; hold_len = vecs[i].hl;
      @(posedge clk);
      ns = 0; nw = 0; na = 0; ne = 0; nt = 0; nboth = 0; cyc = -1;
      finished = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        go = 1'b0;
        if (start) ns++;
        if (busy && !start && !ack) nw++;
        if (ack) na++;
        if (early) ne++;
        if (timeout) nt++;
        if (ack && timeout) nboth++;
        if (ack || timeout) begin
          cyc = int'(cycles);
          finished = 1;
          done = 1'b0;
          break;
        end
        done = (k == vecs[i].done_at);
      end
      done = 1'b0;
      check($sformatf("v%0d_end", i), int'(finished), 1);
      check($sformatf("v%0d_start_len", i), ns, vecs[i].e_start);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].e_cycles);
      check($sformatf("v%0d_ack", i), na, vecs[i].e_ack);
      check($sformatf("v%0d_early", i), ne, vecs[i].e_early);
      check($sformatf("v%0d_timeout", i), nt, vecs[i].e_to);
      check($sformatf("v%0d_wait_len", i), nw, vecs[i].e_wait);
      check($sformatf("v%0d_ack_and_to", i), nboth, 0);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), int'({busy, ack, timeout}), 0);
      @(negedge clk);
    end

    // go held high: ASSERT, WAIT(done), FINISH, IDLE, repeat
    seq_exp = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b110, 3'b010, 3'b011, 3'b000};
    @(negedge clk);
    go = 1'b1; hold_len = 3'd1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_%0d", k), int'({start, busy, ack}), int'(seq_exp[k]));
      done = busy && !start && !ack;
    end
    go = 1'b0; done = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_idle", int'(busy), 0);

    // reset during the second ASSERT cycle
    go = 1'b1; hold_len = 3'd5;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    check("rst_mid_pre_start", int'(start), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_start", int'(start), 0);
    check("rst_mid_outputs", int'({start, busy, ack, early, timeout, cycles}), 0);
    @(negedge clk);
    reset = 1'b1;
    nt = 0; na = 0; ns = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack) na++;
      if (timeout) nt++;
      if (busy || start) ns++;
    end
    check("rst_rel_ack", na, 0);
    check("rst_rel_timeout", nt, 0);
    check("rst_rel_busy", ns, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
